// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// segment bit positions and the scan phase type.
package sevenseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex glyphs, bit0=a ... bit6=g, lowercase b and d to keep them distinct.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/sevenseg_scan_if.sv
// Datapath-side and pin-side signals of the scan driver, grouped so the
// datapath (master) and the driver (slave) share one bundle.
interface sevenseg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      lz_en;
  logic [6:0]                seg;
  logic                      dp;
  logic [NUM_DIGITS-1:0]     an;
  logic                      frame_done;

  modport master (
    output load, value, dp_in, lz_en,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, lz_en,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_seg_decode.sv
// Combinational hex digit to seven-segment glyph lookup.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPHS[digit_i];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex seven-segment driver: shadow-loaded value, one digit
// per slot, blank interval at slot start, optional leading-zero suppression.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  sevenseg_scan_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
  localparam logic [6:0]            SEG_POL   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_POL    = SEG_ACTIVE_LOW;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("sevenseg_scan: NUM_DIGITS must be in 1..16");
  end
  if (BLANK_CYCLES < 0 || REFRESH_DIV < BLANK_CYCLES + 1) begin : g_bad_timing
    $error("sevenseg_scan: need 0 <= BLANK_CYCLES < REFRESH_DIV");
  end

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic                    lz_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_o_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    upper_zero;
  logic [3:0]              cur_digit;
  logic [6:0]              cur_glyph;
  phase_e                  phase;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is suppressed when it and every digit above it are zero;
  // digit 0 always shows so an all-zero value still reads "0".
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_q && upper_zero;
    end
  end

  assign cur_digit = val_q[4*idx_q +: 4];
  assign phase     = (cnt_q < BLANK_END) ? PH_BLANK : PH_DRIVE;
  assign frame_d   = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  seg_decode u_seg_decode (
    .digit_i (cur_digit),
    .seg_o   (cur_glyph)
  );

  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b0;
    an_d  = '0;
    if (phase == PH_DRIVE) begin
      seg_d = lz_mask[idx_q] ? SEG_OFF : cur_glyph;
      dp_d  = sh_dp_q[idx_q];
      an_d  = AN_ONE << idx_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q   <= '0;
      sh_dp_q <= '0;
      lz_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      seg_q   <= SEG_POL;
      dp_o_q  <= DP_POL;
      an_q    <= '0;
      frame_q <= 1'b0;
    end else begin
      // Loading never touches idx/cnt, so the scan keeps its rhythm.
      if (bus.load) begin
        val_q   <= bus.value;
        sh_dp_q <= bus.dp_in;
        lz_q    <= bus.lz_en;
      end
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d ^ SEG_POL;
      dp_o_q  <= dp_d ^ DP_POL;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_o_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench: an active-high and an active-low instance are driven
// identically and compared each cycle against a frame-arithmetic model.
module tb_sevenseg_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    int         tag;
  } exp_t;

  logic clk;
  logic reset;

  sevenseg_scan_if #(.NUM_DIGITS(ND)) bus_ah ();
  sevenseg_scan_if #(.NUM_DIGITS(ND)) bus_al ();

  sevenseg_scan #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_ah (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_ah)
  );

  sevenseg_scan #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_al (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          cur_tag = 0;
  exp_t        exp_q [$];

  // Reference state: edges since reset plus the shadow contents.
  int          m_n = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic        m_lz = 1'b0;

  task automatic check(input string name, input logic [12:0] act,
                       input logic [12:0] want, input int tag);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s tag=%0d t=%0t got {an,seg,dp,fd}=%h want=%h",
               name, tag, $time, act, want);
    end
  endtask

  // Expected active-high outputs for the coming edge.
  function automatic exp_t model_out(input logic rst);
    exp_t        e;
    int          slot;
    int          off;
    logic [15:0] upper;
    e.an  = '0;
    e.seg = 7'h00;
    e.dp  = 1'b0;
    e.fd  = 1'b0;
    e.tag = cur_tag;
    if (!rst) begin
      slot = (m_n / RD) % ND;
      off  = m_n % RD;
      e.fd = (off == RD - 1) && (slot == ND - 1);
      if (off >= BL) begin
        upper = m_val >> (4 * slot);
        e.an  = 4'(1 << slot);
        e.dp  = m_dp[slot];
        e.seg = (m_lz && slot > 0 && upper == 16'h0) ? 7'h00 : GLYPH[upper[3:0]];
      end
    end
    return e;
  endfunction

  task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d,
                      input logic lz, input logic rst);
    @(negedge clk);
    reset        = rst;
    bus_ah.load  = ld;
    bus_ah.value = v;
    bus_ah.dp_in = d;
    bus_ah.lz_en = lz;
    bus_al.load  = ld;
    bus_al.value = v;
    bus_al.dp_in = d;
    bus_al.lz_en = lz;
    exp_q.push_back(model_out(rst));
    if (rst) begin
      m_n   = 0;
      m_val = '0;
      m_dp  = '0;
      m_lz  = 1'b0;
    end else begin
      if (ld) begin
        m_val = v;
        m_dp  = d;
        m_lz  = lz;
      end
      m_n++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    tick(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected record per edge, checked 1 time unit after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("out_ah", {bus_ah.an, bus_ah.seg, bus_ah.dp, bus_ah.frame_done},
            {e.an, e.seg, e.dp, e.fd}, e.tag);
      check("out_al", {bus_al.an, bus_al.seg, bus_al.dp, bus_al.frame_done},
            {e.an, e.seg ^ 7'h7F, ~e.dp, e.fd}, e.tag);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    cur_tag = 1;
    tick(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    tick(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    repeat (2 * FRAME) idle();

    cur_tag = 2;
    tick(1'b1, 16'h12AF, 4'b0100, 1'b0, 1'b0);
    repeat (FRAME) idle();

    cur_tag = 3;
    tick(1'b1, 16'h0050, 4'b0000, 1'b1, 1'b0);
    repeat (FRAME) idle();

    cur_tag = 4;
    tick(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0);
    repeat (FRAME) idle();

    // Mid-DRIVE load of digit 1 (idx=1, cnt=4): 1 -> 8.
    cur_tag = 5;
    tick(1'b1, 16'h0010, 4'b0000, 1'b0, 1'b0);
    while ((m_n % FRAME) != RD + 4) idle();
    tick(1'b1, 16'h0080, 4'b0000, 1'b0, 1'b0);
    repeat (FRAME) idle();

    // Reset at idx=2, cnt=5, with a competing load that must lose.
    cur_tag = 6;
    while ((m_n % FRAME) != 2 * RD + 5) idle();
    tick(1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b1);
    repeat (FRAME + 8) idle();

    cur_tag = 7;
    tick(1'b1, 16'h0008, 4'b0000, 1'b0, 1'b0);
    repeat (FRAME) idle();

    cur_tag = 8;
    for (int k = 0; k < 400; k++) begin
      logic [15:0] v;
      logic [15:0] mask;
      case ($urandom_range(3, 0))
        0:       mask = 16'h000F;
        1:       mask = 16'h00FF;
        2:       mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      v = 16'($urandom) & mask;
      tick(($urandom_range(7, 0) == 0), v, 4'($urandom), 1'($urandom),
           ($urandom_range(63, 0) == 0));
    end

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
